frame_burst_uploader: RTL

Parametrised camera-to-SDRAM frame uploader. It drains a first-word-fall-through pixel/marker queue, packs pixels into memory words, and writes each row to frame memory as fixed-length bursts through the memory controller's request/ack handshake. Partial bursts at row ends are handled with per-pixel write masks. Multi-buffer (ping-pong) frame storage, sticky sync-error flags and continuous re-arm are included. It sits between the camera capture FIFO and the SDRAM arbiter.

---
 rtl/frame_burst_uploader.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/frame_burst_uploader.sv
// frame_burst_uploader: drains a FWFT pixel/marker queue, packs pixels into
// memory words and writes each row to frame memory as fixed-length bursts.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | disarmed, waiting for start
// S_WAIT_FRAME | discarding queue entries until START_FRAME
// S_WAIT_ROW   | between rows, waiting for START_ROW (or END_FRAME)
// S_FILL       | packing pixels of the current burst into the cache
// S_REQ        | write_rq raised, waiting for write_ack
// S_BURST      | streaming BURST_WORDS beats after the ack
// S_TAIL       | holding write_rq until the command window expires
// S_ADVANCE    | stepping column/row after a burst
// S_WAIT_END   | all rows written, waiting for END_FRAME
// S_DONE       | one-cycle frame completion, buffer rotation, re-arm
module frame_burst_uploader #(
  parameter int PIXEL_WIDTH    = 16,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int BURST_PIXELS   = 16,
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int ROW_STRIDE     = FRAME_WIDTH,
  parameter int ADDR_WIDTH     = 21,
  parameter int NUM_BUFFERS    = 2,
  parameter int BUFFER_STRIDE  = FRAME_WIDTH * FRAME_HEIGHT,
  parameter int TCMD           = 19
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [ADDR_WIDTH-1:0]                   base_addr,
  input  logic                                    queue_empty,
  input  logic [PIXEL_WIDTH:0]                    queue_data,
  output logic                                    rd_en,
  output logic                                    write_rq,
  input  logic                                    write_ack,
  output logic [ADDR_WIDTH-1:0]                   write_addr,
  output logic                                    mem_wr_en,
  output logic [MEM_DATA_WIDTH-1:0]               write_data,
  output logic [MEM_DATA_WIDTH/PIXEL_WIDTH-1:0]   write_mask,
  output logic [1:0]                              buffer_index,
  output logic                                    busy,
  output logic                                    upload_done,
  output logic                                    err_sync,
  output logic                                    err_short_frame
);

  localparam int PPW  = MEM_DATA_WIDTH / PIXEL_WIDTH;
  localparam int BW   = BURST_PIXELS / PPW;
  localparam int MAXC = (FRAME_WIDTH > BURST_PIXELS) ? FRAME_WIDTH : BURST_PIXELS;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int RW   = $clog2(FRAME_HEIGHT + 1);
  localparam int BTW  = $clog2(BW + 1);
  localparam int WIW  = (BW > 1) ? $clog2(BW) : 1;
  localparam int LNW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int TW   = $clog2(TCMD + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_FRAME, S_WAIT_ROW, S_FILL, S_REQ,
    S_BURST, S_TAIL, S_ADVANCE, S_WAIT_END, S_DONE
  } state_t;

  state_t                    state;
  logic [CW-1:0]             col, fill_cnt, target, remain;
  logic [RW-1:0]             row;
  logic [ADDR_WIDTH-1:0]     row_base, frame_base;
  logic [BTW-1:0]            beat;
  logic [TW-1:0]             tail_cnt;
  logic [MEM_DATA_WIDTH-1:0] cache [BW];
  logic [MEM_DATA_WIDTH-1:0] beat_word;
  logic [PPW-1:0]            beat_mask;
  logic [WIW-1:0]            fill_word;
  logic [LNW-1:0]            fill_lane;
  logic [PIXEL_WIDTH-1:0]    head_low;
  logic                      is_marker, mk_start_frame, mk_start_row, mk_end_frame;

  assign head_low       = queue_data[PIXEL_WIDTH-1:0];
  assign is_marker      = queue_data[PIXEL_WIDTH];
  assign mk_start_frame = is_marker && (head_low == '0);
  assign mk_start_row   = is_marker && (head_low == PIXEL_WIDTH'(1));
  assign mk_end_frame   = is_marker && (&head_low);

  assign rd_en = !queue_empty && (state == S_WAIT_FRAME || state == S_WAIT_ROW ||
                                  state == S_FILL || state == S_WAIT_END);
  assign busy  = (state != S_IDLE);

  assign frame_base = base_addr + ADDR_WIDTH'(int'(buffer_index) * BUFFER_STRIDE);
  assign remain     = CW'(FRAME_WIDTH) - col;
  assign target     = (remain > CW'(BURST_PIXELS)) ? CW'(BURST_PIXELS) : remain;
  assign fill_word  = WIW'(fill_cnt / CW'(PPW));
  assign fill_lane  = LNW'(fill_cnt % CW'(PPW));

  // Beat word/mask for the beat index about to be driven; slots past target are masked and zeroed.
  always_comb begin
    beat_mask = '0;
    beat_word = '0;
    for (int l = 0; l < PPW; l++)
      beat_mask[l] = ((int'(beat) * PPW + l) < int'(target));
    if (beat_mask != '0)
      beat_word = cache[WIW'(beat)];
  end

  // Main sequencing FSM with registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      write_rq        <= 1'b0;
      write_addr      <= '0;
      mem_wr_en       <= 1'b0;
      write_data      <= '0;
      write_mask      <= '0;
      buffer_index    <= '0;
      upload_done     <= 1'b0;
      err_sync        <= 1'b0;
      err_short_frame <= 1'b0;
      col             <= '0;
      fill_cnt        <= '0;
      row             <= '0;
      row_base        <= '0;
      beat            <= '0;
      tail_cnt        <= '0;
      for (int i = 0; i < BW; i++) cache[i] <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_WAIT_FRAME;
        S_WAIT_FRAME: begin
          if (rd_en && mk_start_frame) begin
            err_sync        <= 1'b0;
            err_short_frame <= 1'b0;
            row             <= '0;
            row_base        <= frame_base;
            state           <= S_WAIT_ROW;
          end
        end
        S_WAIT_ROW: begin
          if (rd_en && is_marker) begin
            if (mk_start_row) begin
              col      <= '0;
              fill_cnt <= '0;
              for (int i = 0; i < BW; i++) cache[i] <= '0;
              state    <= S_FILL;
            end else if (mk_end_frame) begin
              err_short_frame <= 1'b1;
              upload_done     <= 1'b1;
              state           <= S_DONE;
            end else begin
              err_sync <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (rd_en) begin
            if (is_marker) begin
              err_sync <= 1'b1;
            end else begin
              cache[fill_word][fill_lane*PIXEL_WIDTH +: PIXEL_WIDTH] <= head_low;
              fill_cnt <= fill_cnt + CW'(1);
              if (fill_cnt + CW'(1) == target) begin
                write_rq   <= 1'b1;
                write_addr <= row_base + ADDR_WIDTH'(col);
                beat       <= '0;
                state      <= S_REQ;
              end
            end
          end
        end
        S_REQ: begin
          if (write_ack) begin
            mem_wr_en  <= 1'b1;
            write_data <= beat_word;
            write_mask <= beat_mask;
            beat       <= beat + BTW'(1);
            tail_cnt   <= TW'(TCMD - 1);
            state      <= S_BURST;
          end
        end
        S_BURST: begin
          tail_cnt <= tail_cnt - TW'(1);
          if (beat == BTW'(BW)) begin
            mem_wr_en  <= 1'b0;
            write_data <= '0;
            write_mask <= '0;
            state      <= S_TAIL;
          end else begin
            write_data <= beat_word;
            write_mask <= beat_mask;
            beat       <= beat + BTW'(1);
          end
        end
        S_TAIL: begin
          if (tail_cnt == '0) begin
            write_rq <= 1'b0;
            state    <= S_ADVANCE;
          end else begin
            tail_cnt <= tail_cnt - TW'(1);
          end
        end
        S_ADVANCE: begin
          if (col + target == CW'(FRAME_WIDTH)) begin
            row      <= row + RW'(1);
            row_base <= row_base + ADDR_WIDTH'(ROW_STRIDE);
            state    <= (row + RW'(1) == RW'(FRAME_HEIGHT)) ? S_WAIT_END : S_WAIT_ROW;
          end else begin
            col      <= col + target;
            fill_cnt <= '0;
            for (int i = 0; i < BW; i++) cache[i] <= '0;
            state    <= S_FILL;
          end
        end
        S_WAIT_END: begin
          if (rd_en) begin
            if (mk_end_frame) begin
              upload_done <= 1'b1;
              state       <= S_DONE;
            end else begin
              err_sync <= 1'b1;
            end
          end
        end
        S_DONE: begin
          upload_done  <= 1'b0;
          buffer_index <= (buffer_index == 2'(NUM_BUFFERS - 1)) ? 2'd0 : buffer_index + 2'd1;
          state        <= start ? S_WAIT_FRAME : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
